// File: rtl/aoi221_arc_pkg.sv
// Shared types and constants for the aoi221 arc-walk sequencer.
// The pin vector is packed MSB-first as {a1, a2, b1, b2, c}.
package aoi221_arc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAssert,
    StRelease,
    StFin
  } state_e;

  localparam int unsigned NUM_ARCS = 21;
  localparam logic [4:0]  NO_ERR   = 5'h1F;

  typedef struct packed {
    logic a1;
    logic a2;
    logic b1;
    logic b2;
    logic c;
  } pins_t;

  // Static side-pin pattern for sub-index 0,1,2 -> 00, 01, 10.
  function automatic logic [1:0] pat2(input logic [4:0] j);
    case (j)
      5'd0:    pat2 = 2'b00;
      5'd1:    pat2 = 2'b01;
      default: pat2 = 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/aoi221_arc_rom.sv
// Combinational arc table: arc index -> static base vector and toggle-pin mask.
module aoi221_arc_rom
  import aoi221_arc_pkg::*;
(
  input  logic [4:0] i_arc,
  output pins_t      o_base,
  output pins_t      o_mask
);

  logic [4:0] w_k;
  logic [1:0] w_pa;
  logic [1:0] w_pb;

  always_comb begin
    o_base = '0;
    o_mask = '0;
    w_k    = '0;
    w_pa   = '0;
    w_pb   = '0;
    if (i_arc < 5'd3) begin
      w_pb   = pat2(i_arc);
      o_base = {1'b0, 1'b1, w_pb, 1'b0};
      o_mask = 5'b10000;
    end else if (i_arc < 5'd6) begin
      w_pb   = pat2(i_arc - 5'd3);
      o_base = {1'b1, 1'b0, w_pb, 1'b0};
      o_mask = 5'b01000;
    end else if (i_arc < 5'd9) begin
      w_pa   = pat2(i_arc - 5'd6);
      o_base = {w_pa, 1'b0, 1'b1, 1'b0};
      o_mask = 5'b00100;
    end else if (i_arc < 5'd12) begin
      w_pa   = pat2(i_arc - 5'd9);
      o_base = {w_pa, 1'b1, 1'b0, 1'b0};
      o_mask = 5'b00010;
    end else begin
      // C arcs walk A1A2 in the outer loop and B1B2 in the inner loop.
      w_k = i_arc - 5'd12;
      if (w_k < 5'd3) begin
        w_pa = 2'b00;
        w_pb = pat2(w_k);
      end else if (w_k < 5'd6) begin
        w_pa = 2'b01;
        w_pb = pat2(w_k - 5'd3);
      end else begin
        w_pa = 2'b10;
        w_pb = pat2(w_k - 5'd6);
      end
      o_base = {w_pa, w_pb, 1'b0};
      o_mask = 5'b00001;
    end
  end

endmodule

// File: rtl/aoi221_arc_sequencer.sv
// Walks all 21 conditional timing arcs of one aoi221 cell and checks ZN per phase.
// Launch takes one cycle after START so the first vector appears one edge after acceptance.
module aoi221_arc_sequencer
  import aoi221_arc_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rn,
  input  logic             i_start,
  input  logic             i_zn,
  output logic             o_a1,
  output logic             o_a2,
  output logic             o_b1,
  output logic             o_b2,
  output logic             o_c,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [4:0]       o_first_err_arc,
  output logic [4:0]       o_arc_idx
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);
  localparam logic [4:0] LAST_ARC = 5'(NUM_ARCS - 1);

  state_e           r_state, w_state_d;
  logic [3:0]       r_cnt, w_cnt_d;
  logic [4:0]       r_arc, w_arc_d;
  logic             r_launch, w_launch_d;
  logic [ERR_W-1:0] r_err, w_err_d;
  logic [4:0]       r_first, w_first_d;
  logic             r_pass, w_pass_d;
  pins_t            r_pins, w_pins_d;
  logic             r_busy, r_done;
  pins_t            w_base, w_mask;
  logic             w_exp, w_mis, w_phase_d;

  aoi221_arc_rom u_rom (
    .i_arc  (w_arc_d),
    .o_base (w_base),
    .o_mask (w_mask)
  );

  assign w_exp = (r_state != StAssert);
  assign w_mis = (i_zn !== w_exp);

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_arc_d    = r_arc;
    w_launch_d = 1'b0;
    w_err_d    = r_err;
    w_first_d  = r_first;
    w_pass_d   = r_pass;
    unique case (r_state)
      StIdle: begin
        if (r_launch) begin
          w_state_d = StSetup;
          w_cnt_d   = '0;
        end else if (i_start) begin
          w_launch_d = 1'b1;
          w_err_d    = '0;
          w_first_d  = NO_ERR;
          w_arc_d    = '0;
          w_pass_d   = 1'b0;
        end
      end
      StSetup, StAssert, StRelease: begin
        if (r_cnt == SETTLE_L) begin
          w_cnt_d = '0;
          if (w_mis) begin
            if (r_err != {ERR_W{1'b1}}) w_err_d = r_err + ERR_W'(1);
            if (r_first == NO_ERR) w_first_d = r_arc;
          end
          if (r_state == StSetup) begin
            w_state_d = StAssert;
          end else if (r_state == StAssert) begin
            w_state_d = StRelease;
          end else if (r_arc == LAST_ARC) begin
            w_state_d = StFin;
            w_pass_d  = (w_err_d == '0);
          end else begin
            w_arc_d   = r_arc + 5'd1;
            w_state_d = StSetup;
          end
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Pins are registered from the next state so they line up with the phase they belong to.
  always_comb begin
    w_phase_d = (w_state_d == StSetup) || (w_state_d == StAssert) || (w_state_d == StRelease);
    w_pins_d  = '0;
    if (w_phase_d) w_pins_d = w_base | ((w_state_d == StAssert) ? w_mask : pins_t'('0));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rn) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_arc    <= '0;
      r_launch <= 1'b0;
      r_err    <= '0;
      r_first  <= NO_ERR;
      r_pass   <= 1'b0;
      r_pins   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_arc    <= w_arc_d;
      r_launch <= w_launch_d;
      r_err    <= w_err_d;
      r_first  <= w_first_d;
      r_pass   <= w_pass_d;
      r_pins   <= w_pins_d;
      r_busy   <= w_phase_d;
      r_done   <= (w_state_d == StFin);
    end
  end

  assign o_a1            = r_pins.a1;
  assign o_a2            = r_pins.a2;
  assign o_b1            = r_pins.b1;
  assign o_b2            = r_pins.b2;
  assign o_c             = r_pins.c;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_pass          = r_pass;
  assign o_err_cnt       = r_err;
  assign o_first_err_arc = r_first;
  assign o_arc_idx       = r_arc;

endmodule

// File: tb/tb_aoi221_arc_sequencer.sv
// Directed bench: two sequencer instances (SETTLE=2 and SETTLE=0) driving behavioural cell models.
module tb_aoi221_arc_sequencer;

  logic clk;
  logic rn0, start0, zn0, rn1, start1, zn1;
  logic a1_0, a2_0, b1_0, b2_0, c_0, busy0, done0, pass0;
  logic a1_1, a2_1, b1_1, b2_1, c_1, busy1, done1, pass1;
  logic [4:0] err0, first0, arc0, err1, first1, arc1;
  logic [4:0] pins0, pins1;
  int mode0, mode1;
  int total, bad;

  assign pins0 = {a1_0, a2_0, b1_0, b2_0, c_0};
  assign pins1 = {a1_1, a2_1, b1_1, b2_1, c_1};

  aoi221_arc_sequencer #(.SETTLE(2), .ERR_W(5)) u_dut0 (
    .i_clk(clk), .i_rn(rn0), .i_start(start0), .i_zn(zn0),
    .o_a1(a1_0), .o_a2(a2_0), .o_b1(b1_0), .o_b2(b2_0), .o_c(c_0),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_cnt(err0),
    .o_first_err_arc(first0), .o_arc_idx(arc0)
  );

  aoi221_arc_sequencer #(.SETTLE(0), .ERR_W(5)) u_dut1 (
    .i_clk(clk), .i_rn(rn1), .i_start(start1), .i_zn(zn1),
    .o_a1(a1_1), .o_a2(a2_1), .o_b1(b1_1), .o_b2(b2_1), .o_c(c_1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_cnt(err1),
    .o_first_err_arc(first1), .o_arc_idx(arc1)
  );

  // mode 0: ideal cell, 1: ZN stuck-at-0, 2: C input ignored
  function automatic logic zn_model(input int mode, input logic [4:0] p);
    logic ab;
    ab = (p[4] & p[3]) | (p[2] & p[1]);
    if (mode == 1) zn_model = 1'b0;
    else if (mode == 2) zn_model = !ab;
    else zn_model = !(ab | p[0]);
  endfunction

  always_comb zn0 = zn_model(mode0, pins0);
  always_comb zn1 = zn_model(mode1, pins1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rn0 = 1'b0; rn1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    tick(); tick();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done0); end
    total++; if (pass0 !== 1'b0) begin bad++; $display("FAIL rst_pass: got %b want 0", pass0); end
    total++; if (pins0 !== 5'b0) begin bad++; $display("FAIL rst_pins: got %b want 00000", pins0); end
    total++; if (err0 !== 5'd0) begin bad++; $display("FAIL rst_err: got %0d want 0", err0); end
    total++;
    if (first0 !== 5'h1F) begin bad++; $display("FAIL rst_first: got %h want 1f", first0); end
    total++; if (arc0 !== 5'd0) begin bad++; $display("FAIL rst_arc: got %0d want 0", arc0); end
    rn0 = 1'b1; rn1 = 1'b1;
    tick();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy0); end
  endtask

  task automatic test_ideal();
    int n;
    mode0 = 0;
    start0 = 1'b1; tick(); start0 = 1'b0;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL launch_busy: got %b want 0", busy0); end
    n = 0;
    do begin
      tick(); n++;
      if (n == 1) begin
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL c1_busy: got %b want 1", busy0); end
        total++;
        if (pins0 !== 5'b01000) begin bad++; $display("FAIL c1_pins: got %b want 01000", pins0); end
      end
      if (n == 66) begin
        total++;
        if (pins0 !== 5'b01010) begin bad++; $display("FAIL arc7_setup: got %b want 01010", pins0); end
      end
      if (n == 67 || n == 69) begin
        total++;
        if (pins0 !== 5'b01110) begin bad++; $display("FAIL arc7_assert: got %b want 01110", pins0); end
        total++; if (arc0 !== 5'd7) begin bad++; $display("FAIL arc7_idx: got %0d want 7", arc0); end
      end
    end while (!done0 && n < 1000);
    total++; if (n !== 190) begin bad++; $display("FAIL ideal_done_cycle: got %0d want 190", n); end
    total++; if (pass0 !== 1'b1) begin bad++; $display("FAIL ideal_pass: got %b want 1", pass0); end
    total++; if (err0 !== 5'd0) begin bad++; $display("FAIL ideal_err: got %0d want 0", err0); end
    total++;
    if (first0 !== 5'h1F) begin bad++; $display("FAIL ideal_first: got %h want 1f", first0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL ideal_busy: got %b want 0", busy0); end
    total++; if (pins0 !== 5'b0) begin bad++; $display("FAIL ideal_pins: got %b want 0", pins0); end
    tick();
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", done0); end
    total++; if (pass0 !== 1'b1) begin bad++; $display("FAIL pass_held: got %b want 1", pass0); end
  endtask

  task automatic test_stuck0();
    int n;
    mode0 = 1;
    start0 = 1'b1; tick(); start0 = 1'b0;
    total++; if (pass0 !== 1'b0) begin bad++; $display("FAIL start_clr_pass: got %b want 0", pass0); end
    n = 0;
    do begin tick(); n++; end while (!done0 && n < 1000);
    total++; if (n !== 190) begin bad++; $display("FAIL stuck_done_cycle: got %0d want 190", n); end
    total++; if (err0 !== 5'd31) begin bad++; $display("FAIL stuck_err: got %0d want 31", err0); end
    total++; if (first0 !== 5'd0) begin bad++; $display("FAIL stuck_first: got %0d want 0", first0); end
    total++; if (pass0 !== 1'b0) begin bad++; $display("FAIL stuck_pass: got %b want 0", pass0); end
    tick();
  endtask

  task automatic test_c_ignored();
    int n;
    mode0 = 2;
    start0 = 1'b1; tick(); start0 = 1'b0;
    total++; if (err0 !== 5'd0) begin bad++; $display("FAIL start_clr_err: got %0d want 0", err0); end
    total++;
    if (first0 !== 5'h1F) begin bad++; $display("FAIL start_clr_first: got %h want 1f", first0); end
    n = 0;
    do begin tick(); n++; end while (!done0 && n < 1000);
    total++; if (n !== 190) begin bad++; $display("FAIL cign_done_cycle: got %0d want 190", n); end
    total++; if (err0 !== 5'd9) begin bad++; $display("FAIL cign_err: got %0d want 9", err0); end
    total++; if (first0 !== 5'd12) begin bad++; $display("FAIL cign_first: got %0d want 12", first0); end
    total++; if (pass0 !== 1'b0) begin bad++; $display("FAIL cign_pass: got %b want 0", pass0); end
    tick();
  endtask

  task automatic test_reset_midrun();
    int n;
    mode0 = 1;
    start0 = 1'b1; tick(); start0 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (n < 50);
    rn0 = 1'b0; start0 = 1'b1;
    tick();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy0); end
    total++; if (pins0 !== 5'b0) begin bad++; $display("FAIL mid_pins: got %b want 0", pins0); end
    total++; if (err0 !== 5'd0) begin bad++; $display("FAIL mid_err: got %0d want 0", err0); end
    total++;
    if (first0 !== 5'h1F) begin bad++; $display("FAIL mid_first: got %h want 1f", first0); end
    total++; if (arc0 !== 5'd0) begin bad++; $display("FAIL mid_arc: got %0d want 0", arc0); end
    tick();
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL mid_hold: got %b want 0", busy0); end
    mode0 = 0;
    rn0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!done0 && n < 1000);
    total++; if (n !== 190) begin bad++; $display("FAIL rerun_done_cycle: got %0d want 190", n); end
    total++; if (pass0 !== 1'b1) begin bad++; $display("FAIL rerun_pass: got %b want 1", pass0); end
  endtask

  task automatic test_settle0();
    int n;
    mode1 = 0;
    start1 = 1'b1; tick(); start1 = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      start1 = (n == 30);
    end while (!done1 && n < 1000);
    start1 = 1'b0;
    total++; if (n !== 64) begin bad++; $display("FAIL s0_done_cycle: got %0d want 64", n); end
    total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL s0_pass: got %b want 1", pass1); end
  endtask

  task automatic test_back_to_back();
    int n;
    start1 = 1'b1;
    tick();
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b_fin_busy: got %b want 0", busy1); end
    tick();
    start1 = 1'b0;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b_launch: got %b want 0", busy1); end
    n = 0;
    do begin
      tick(); n++;
      if (n == 1) begin
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy1); end
      end
    end while (!done1 && n < 1000);
    total++; if (n !== 64) begin bad++; $display("FAIL b2b_done_cycle: got %0d want 64", n); end
    total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL b2b_pass: got %b want 1", pass1); end
  endtask

  initial begin
    total = 0; bad = 0; mode0 = 0; mode1 = 0;
    rn0 = 1'b0; rn1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    test_reset();
    test_ideal();
    test_stuck0();
    test_c_ignored();
    test_reset_midrun();
    test_settle0();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
